// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side forwarding, operand muxing and
// load-use hazard detection; feeds the ALU directly.
module id_ex_stage #(
   parameter int XLEN   = 32,
   parameter int REGIDX = 5
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              ID_VALID,
   input  logic [XLEN-1:0]   ID_PC,
   input  logic [XLEN-1:0]   ID_RS1_DATA,
   input  logic [XLEN-1:0]   ID_RS2_DATA,
   input  logic [XLEN-1:0]   ID_IMM,
   input  logic [REGIDX-1:0] ID_RS1,
   input  logic [REGIDX-1:0] ID_RS2,
   input  logic [REGIDX-1:0] ID_RD,
   input  logic [3:0]        ID_ALUCTRL,
   input  logic [3:0]        ID_BRANCHCOND,
   input  logic              ID_ALUSRC,
   input  logic              ID_PCSRC,
   input  logic              ID_MEMREAD,
   input  logic              ID_MEMWRITE,
   input  logic              ID_REGWRITE,
   input  logic              FLUSH,
   input  logic              EXMEM_REGWRITE,
   input  logic [REGIDX-1:0] EXMEM_RD,
   input  logic [XLEN-1:0]   EXMEM_RESULT,
   input  logic              MEMWB_REGWRITE,
   input  logic [REGIDX-1:0] MEMWB_RD,
   input  logic [XLEN-1:0]   MEMWB_RESULT,
   output logic [XLEN-1:0]   ALU_A,
   output logic [XLEN-1:0]   ALU_B,
   output logic [3:0]        ALU_CTRL,
   output logic [3:0]        ALU_BRANCHCOND,
   output logic [XLEN-1:0]   EX_STORE_DATA,
   output logic [XLEN-1:0]   EX_PC,
   output logic [REGIDX-1:0] EX_RD,
   output logic              EX_VALID,
   output logic              EX_MEMREAD,
   output logic              EX_MEMWRITE,
   output logic              EX_REGWRITE,
   output logic              STALL
);

   typedef struct packed {
      logic              valid;
      logic              memread;
      logic              memwrite;
      logic              regwrite;
      logic              alusrc;
      logic              pcsrc;
      logic [3:0]        aluctrl;
      logic [3:0]        brcond;
      logic [REGIDX-1:0] rs1;
      logic [REGIDX-1:0] rs2;
      logic [REGIDX-1:0] rd;
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   rs1_data;
      logic [XLEN-1:0]   rs2_data;
      logic [XLEN-1:0]   imm;
   } ex_reg_t;

   ex_reg_t ex_q, id_d;

   logic          ex1_hit, ex2_hit, wb1_hit, wb2_hit;
   logic [XLEN-1:0] fwd_rs1, fwd_rs2;

   // an all-zero struct is the bubble: ADD, no branch, no side effects
   always_comb begin
      id_d          = '0;
      id_d.valid    = ID_VALID;
      id_d.memread  = ID_VALID & ID_MEMREAD;
      id_d.memwrite = ID_VALID & ID_MEMWRITE;
      id_d.regwrite = ID_VALID & ID_REGWRITE;
      id_d.alusrc   = ID_ALUSRC;
      id_d.pcsrc    = ID_PCSRC;
      id_d.aluctrl  = ID_ALUCTRL;
      id_d.brcond   = ID_BRANCHCOND;
      id_d.rs1      = ID_RS1;
      id_d.rs2      = ID_RS2;
      id_d.rd       = ID_RD;
      id_d.pc       = ID_PC;
      id_d.rs1_data = ID_RS1_DATA;
      id_d.rs2_data = ID_RS2_DATA;
      id_d.imm      = ID_IMM;
   end

   // rs2 is compared even when unused; a spurious one-cycle stall is harmless
   assign STALL = ex_q.valid && ex_q.memread && (ex_q.rd != '0) && ID_VALID &&
                  ((ID_RS1 == ex_q.rd) || (ID_RS2 == ex_q.rd)) && !FLUSH;

   always_ff @(posedge CLK) begin
      if (RST || FLUSH || STALL) ex_q <= '0;
      else                       ex_q <= id_d;
   end

   assign ex1_hit = EXMEM_REGWRITE && (EXMEM_RD != '0) && (EXMEM_RD == ex_q.rs1);
   assign ex2_hit = EXMEM_REGWRITE && (EXMEM_RD != '0) && (EXMEM_RD == ex_q.rs2);
   assign wb1_hit = MEMWB_REGWRITE && (MEMWB_RD != '0) && (MEMWB_RD == ex_q.rs1);
   assign wb2_hit = MEMWB_REGWRITE && (MEMWB_RD != '0) && (MEMWB_RD == ex_q.rs2);

   assign fwd_rs1 = ex1_hit ? EXMEM_RESULT : wb1_hit ? MEMWB_RESULT : ex_q.rs1_data;
   assign fwd_rs2 = ex2_hit ? EXMEM_RESULT : wb2_hit ? MEMWB_RESULT : ex_q.rs2_data;

   assign ALU_A          = ex_q.pcsrc  ? ex_q.pc  : fwd_rs1;
   assign ALU_B          = ex_q.alusrc ? ex_q.imm : fwd_rs2;
   assign EX_STORE_DATA  = fwd_rs2;
   assign ALU_CTRL       = ex_q.aluctrl;
   assign ALU_BRANCHCOND = ex_q.brcond;
   assign EX_PC          = ex_q.pc;
   assign EX_RD          = ex_q.rd;
   assign EX_VALID       = ex_q.valid;
   assign EX_MEMREAD     = ex_q.memread;
   assign EX_MEMWRITE    = ex_q.memwrite;
   assign EX_REGWRITE    = ex_q.regwrite;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them.
module tb_id_ex_stage;
   logic        CLK = 0, RST = 1;
   logic        ID_VALID, ID_ALUSRC, ID_PCSRC, ID_MEMREAD, ID_MEMWRITE, ID_REGWRITE;
   logic [31:0] ID_PC, ID_RS1_DATA, ID_RS2_DATA, ID_IMM;
   logic [4:0]  ID_RS1, ID_RS2, ID_RD;
   logic [3:0]  ID_ALUCTRL, ID_BRANCHCOND;
   logic        FLUSH = 0, EXMEM_REGWRITE, MEMWB_REGWRITE;
   logic [4:0]  EXMEM_RD, MEMWB_RD;
   logic [31:0] EXMEM_RESULT, MEMWB_RESULT;
   logic [31:0] ALU_A, ALU_B, EX_STORE_DATA, EX_PC;
   logic [3:0]  ALU_CTRL, ALU_BRANCHCOND;
   logic [4:0]  EX_RD;
   logic        EX_VALID, EX_MEMREAD, EX_MEMWRITE, EX_REGWRITE, STALL;

   id_ex_stage #(.XLEN(32), .REGIDX(5)) dut (
      .CLK(CLK), .RST(RST), .ID_VALID(ID_VALID), .ID_PC(ID_PC),
      .ID_RS1_DATA(ID_RS1_DATA), .ID_RS2_DATA(ID_RS2_DATA), .ID_IMM(ID_IMM),
      .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_RD(ID_RD),
      .ID_ALUCTRL(ID_ALUCTRL), .ID_BRANCHCOND(ID_BRANCHCOND),
      .ID_ALUSRC(ID_ALUSRC), .ID_PCSRC(ID_PCSRC), .ID_MEMREAD(ID_MEMREAD),
      .ID_MEMWRITE(ID_MEMWRITE), .ID_REGWRITE(ID_REGWRITE), .FLUSH(FLUSH),
      .EXMEM_REGWRITE(EXMEM_REGWRITE), .EXMEM_RD(EXMEM_RD), .EXMEM_RESULT(EXMEM_RESULT),
      .MEMWB_REGWRITE(MEMWB_REGWRITE), .MEMWB_RD(MEMWB_RD), .MEMWB_RESULT(MEMWB_RESULT),
      .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_CTRL(ALU_CTRL), .ALU_BRANCHCOND(ALU_BRANCHCOND),
      .EX_STORE_DATA(EX_STORE_DATA), .EX_PC(EX_PC), .EX_RD(EX_RD),
      .EX_VALID(EX_VALID), .EX_MEMREAD(EX_MEMREAD), .EX_MEMWRITE(EX_MEMWRITE),
      .EX_REGWRITE(EX_REGWRITE), .STALL(STALL)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int          id;
      logic [31:0] a, b, st, pc;
      logic [4:0]  rd;
      logic [3:0]  ctrl, bc;
      logic        v, mr, mw, rw, stall;
   } exp_t;

   exp_t sb[$];
   int   checks = 0, failures = 0;
   int   cyc = 0;

   task automatic chk(input int id, input string fld, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL cyc%0d.%s got=%h exp=%h", id, fld, got, want);
      end
   endtask

   always @(negedge CLK) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk(e.id, "alu_a", ALU_A, e.a);
         chk(e.id, "alu_b", ALU_B, e.b);
         chk(e.id, "store", EX_STORE_DATA, e.st);
         chk(e.id, "pc", EX_PC, e.pc);
         chk(e.id, "rd", {27'd0, EX_RD}, {27'd0, e.rd});
         chk(e.id, "ctrl", {28'd0, ALU_CTRL}, {28'd0, e.ctrl});
         chk(e.id, "bcond", {28'd0, ALU_BRANCHCOND}, {28'd0, e.bc});
         chk(e.id, "valid", {31'd0, EX_VALID}, {31'd0, e.v});
         chk(e.id, "memread", {31'd0, EX_MEMREAD}, {31'd0, e.mr});
         chk(e.id, "memwrite", {31'd0, EX_MEMWRITE}, {31'd0, e.mw});
         chk(e.id, "regwrite", {31'd0, EX_REGWRITE}, {31'd0, e.rw});
         chk(e.id, "stall", {31'd0, STALL}, {31'd0, e.stall});
      end
   end

   task automatic step();
      @(posedge CLK); #1;
      cyc++;
   endtask

   task automatic expect_out(input logic [31:0] a, b, st, pc, input logic [4:0] rd,
                             input logic [3:0] ctrl, bc, input logic v, mr, mw, rw, stall);
      exp_t e;
      e.id = cyc; e.a = a; e.b = b; e.st = st; e.pc = pc; e.rd = rd;
      e.ctrl = ctrl; e.bc = bc; e.v = v; e.mr = mr; e.mw = mw; e.rw = rw; e.stall = stall;
      sb.push_back(e);
   endtask

   task automatic expect_bubble(input logic stall);
      expect_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, stall);
   endtask

   task automatic id_set(input logic v, input logic [31:0] pc, r1d, r2d, imm,
                         input logic [4:0] rs1, rs2, rd, input logic [3:0] ctrl, bc,
                         input logic alusrc, pcsrc, mr, mw, rw);
      ID_VALID = v; ID_PC = pc; ID_RS1_DATA = r1d; ID_RS2_DATA = r2d; ID_IMM = imm;
      ID_RS1 = rs1; ID_RS2 = rs2; ID_RD = rd; ID_ALUCTRL = ctrl; ID_BRANCHCOND = bc;
      ID_ALUSRC = alusrc; ID_PCSRC = pcsrc; ID_MEMREAD = mr; ID_MEMWRITE = mw; ID_REGWRITE = rw;
   endtask

   task automatic fwd_set(input logic exw, input logic [4:0] exrd, input logic [31:0] exres,
                          input logic wbw, input logic [4:0] wbrd, input logic [31:0] wbres);
      EXMEM_REGWRITE = exw; EXMEM_RD = exrd; EXMEM_RESULT = exres;
      MEMWB_REGWRITE = wbw; MEMWB_RD = wbrd; MEMWB_RESULT = wbres;
   endtask

   initial begin
      // garbage everywhere while reset is held
      id_set(1, 32'hDEADBEEF, 32'h12345678, 32'h9ABCDEF0, 32'h55555555,
             5'd5, 5'd6, 5'd7, 4'hF, 4'hF, 1, 1, 1, 1, 1);
      fwd_set(1, 5'd9, 32'hCAFE0001, 1, 5'd10, 32'hCAFE0002);

      step(); expect_bubble(0);                       // reset edge 1
      step(); expect_bubble(0);                       // reset edge 2
      RST = 0;
      fwd_set(0, 0, 0, 0, 0, 0);
      id_set(1, 32'h40, 32'd5, 32'd7, 0, 5'd1, 5'd2, 5'd3, 4'h0, 4'h0, 0, 0, 0, 0, 1);

      step(); expect_out(5, 7, 7, 32'h40, 3, 0, 0, 1, 0, 0, 1, 0);   // add x3,x1,x2
      id_set(1, 32'h44, 32'h10, 32'h20, 0, 5'd3, 5'd9, 5'd4, 4'h1, 4'h0, 0, 0, 0, 0, 1);

      step(); fwd_set(1, 5'd3, 32'hAA, 1, 5'd3, 32'hBB);
      expect_out(32'hAA, 32'h20, 32'h20, 32'h44, 4, 1, 0, 1, 0, 0, 1, 0);
      step(); fwd_set(0, 5'd3, 32'hAA, 1, 5'd3, 32'hBB);
      expect_out(32'hBB, 32'h20, 32'h20, 32'h44, 4, 1, 0, 1, 0, 0, 1, 0);
      step(); fwd_set(1, 5'd0, 32'hAA, 1, 5'd0, 32'hBB);
      expect_out(32'h10, 32'h20, 32'h20, 32'h44, 4, 1, 0, 1, 0, 0, 1, 0);
      step(); fwd_set(1, 5'd9, 32'h99, 1, 5'd3, 32'hBB);
      expect_out(32'hBB, 32'h99, 32'h99, 32'h44, 4, 1, 0, 1, 0, 0, 1, 0);
      id_set(1, 32'h48, 32'h1000, 0, 32'd8, 5'd2, 5'd0, 5'd5, 4'h0, 4'h0, 1, 0, 1, 0, 1);

      // load-use: lw x5 then add x6,x5,x1
      step(); fwd_set(0, 0, 0, 0, 0, 0);
      id_set(1, 32'h4C, 32'h55, 32'h3, 0, 5'd5, 5'd1, 5'd6, 4'h0, 4'h0, 0, 0, 0, 0, 1);
      expect_out(32'h1000, 8, 0, 32'h48, 5, 0, 0, 1, 1, 0, 1, 1);
      step(); expect_bubble(0);
      step(); fwd_set(0, 0, 0, 1, 5'd5, 32'h777);
      expect_out(32'h777, 3, 3, 32'h4C, 6, 0, 0, 1, 0, 0, 1, 0);
      id_set(1, 32'h50, 1, 2, 0, 5'd1, 5'd2, 5'd0, 4'h1, 4'h8, 0, 0, 0, 0, 0);
      FLUSH = 1;

      // flushed beq, then flush masking a load-use match
      step(); FLUSH = 0; fwd_set(0, 0, 0, 0, 0, 0);
      expect_bubble(0);
      id_set(1, 32'h54, 32'h2000, 0, 32'd4, 5'd2, 5'd0, 5'd5, 4'h0, 4'h0, 1, 0, 1, 0, 1);
      step();
      id_set(1, 32'h58, 1, 2, 0, 5'd1, 5'd5, 5'd7, 4'h0, 4'h0, 0, 0, 0, 0, 1);
      FLUSH = 1;
      expect_out(32'h2000, 4, 0, 32'h54, 5, 0, 0, 1, 1, 0, 1, 0);
      step(); FLUSH = 0; expect_bubble(0);
      id_set(1, 32'h5C, 32'h30, 32'h50, 32'hFFFFFFFC, 5'd1, 5'd4, 5'd8, 4'h0, 4'h0, 1, 0, 0, 0, 1);

      // addi with forwarded rs2, then auipc
      step(); fwd_set(1, 5'd4, 32'h11, 0, 0, 0);
      expect_out(32'h30, 32'hFFFFFFFC, 32'h11, 32'h5C, 8, 0, 0, 1, 0, 0, 1, 0);
      id_set(1, 32'h100, 32'hDEAD, 0, 32'h1000, 5'd7, 5'd0, 5'd9, 4'h0, 4'h0, 1, 1, 0, 0, 1);
      step(); fwd_set(0, 0, 0, 0, 0, 0);
      expect_out(32'h100, 32'h1000, 0, 32'h100, 9, 0, 0, 1, 0, 0, 1, 0);
      id_set(0, 32'h104, 32'h77, 32'h66, 0, 5'd3, 5'd4, 5'd10, 4'h2, 4'h0, 0, 0, 1, 1, 1);

      // invalid ID: data captured, control forced low
      step(); expect_out(32'h77, 32'h66, 32'h66, 32'h104, 10, 2, 0, 0, 0, 0, 0, 0);
      id_set(1, 32'h108, 32'h4, 0, 0, 5'd1, 5'd0, 5'd5, 4'h0, 4'h0, 1, 0, 1, 0, 1);

      // rs2-only load-use match, with reset arriving during the stall
      step();
      id_set(1, 32'h10C, 32'h8, 32'h9, 32'h10, 5'd1, 5'd5, 5'd0, 4'h0, 4'h0, 0, 0, 0, 1, 0);
      RST = 1;
      expect_out(32'h4, 0, 0, 32'h108, 5, 0, 0, 1, 1, 0, 1, 1);
      step(); RST = 0; expect_bubble(0);
      step(); expect_out(32'h8, 32'h9, 32'h9, 32'h10C, 0, 0, 0, 1, 0, 1, 0, 0);

      for (int i = 0; i < 10 && sb.size() > 0; i++) step();
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d required=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and EX-side operand selection for the 5-stage pipelined core. Sits directly upstream of the ALU and feeds its A, B, CTRL and BRANCHCONDITION inputs.
- Captures decoded instructions from ID and applies forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards, inserts bubbles and honours branch flushes.

Parameters:
- XLEN, 32, datapath width.
- REGIDX, 5, register index width.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  synchronous, active-high reset.
- ID_VALID  in  1  ID holds a real instruction.
- ID_PC  in  XLEN  instruction PC.
- ID_RS1_DATA, ID_RS2_DATA  in  XLEN  register file read data.
- ID_IMM  in  XLEN  sign-extended immediate.
- ID_RS1, ID_RS2, ID_RD  in  REGIDX  register indices.
- ID_ALUCTRL  in  4  ALU opcode: ADD=0000, SUB=0001 … SLTU=1001.
- ID_BRANCHCOND  in  4  branch code: BEQ=1000, BNE=1001, JMP=1010, BLT..BGEU=1100..1111, none=0xxx.
- ID_ALUSRC  in  1  1: ALU B = immediate.
- ID_PCSRC  in  1  1: ALU A = PC (AUIPC/JAL).
- ID_MEMREAD, ID_MEMWRITE, ID_REGWRITE  in  1  control bits.
- FLUSH  in  1  branch taken in EX; kill the instruction entering EX.
- EXMEM_REGWRITE  in  1  EX/MEM instruction writes rd.
- EXMEM_RD  in  REGIDX  EX/MEM destination.
- EXMEM_RESULT  in  XLEN  EX/MEM ALU result.
- MEMWB_REGWRITE  in  1  MEM/WB instruction writes rd.
- MEMWB_RD  in  REGIDX  MEM/WB destination.
- MEMWB_RESULT  in  XLEN  MEM/WB write-back value.
- ALU_A, ALU_B  out  XLEN  ALU operands.
- ALU_CTRL  out  4  to ALU CTRL.
- ALU_BRANCHCOND  out  4  to ALU BRANCHCONDITION.
- EX_STORE_DATA  out  XLEN  forwarded rs2 value for stores.
- EX_PC  out  XLEN  registered PC.
- EX_RD  out  REGIDX  registered rd.
- EX_VALID, EX_MEMREAD, EX_MEMWRITE, EX_REGWRITE  out  1  registered control bits.
- STALL  out  1  hold PC and IF/ID this cycle (combinational).

Behaviour:
- **Register update (rising edge), priority order:**
  - **RST:** load bubble.
  - **FLUSH:** load bubble.
  - **STALL:** load bubble.
  - **Otherwise:** capture all ID_* inputs; EX_VALID <= ID_VALID.
  - If ID_VALID=0, the register still captures, but the valid/memory/regwrite control bits are forced to 0.
- **Bubble:**
  - EX_VALID, EX_MEMREAD, EX_MEMWRITE and EX_REGWRITE = 0.
  - Registered ALUCTRL = 0000 (ADD); BRANCHCOND = 0000 (none).
  - rd, PC, data and imm = 0.
  - All outputs take these values from the first edge with RST high.
- **STALL:**
  - Asserted when EX_VALID & EX_MEMREAD & EX_RD≠0 & ID_VALID & (ID_RS1==EX_RD | ID_RS2==EX_RD) & ~FLUSH.
  - Rs2 is compared conservatively, even for instructions that do not use rs2.
  - A stall lasts exactly one cycle, because the next cycle's EX holds a bubble.
- **Forwarding (combinational on registered rs1/rs2), applied per operand:**
  - If EXMEM_REGWRITE & EXMEM_RD≠0 & EXMEM_RD==rs: use EXMEM_RESULT.
  - Else if MEMWB_REGWRITE & MEMWB_RD≠0 & MEMWB_RD==rs: use MEMWB_RESULT.
  - Else use the registered read data.
  - EX/MEM has priority over MEM/WB.
  - x0 is never forwarded.
  - Same-cycle WB-to-ID write-through is the register file's responsibility, not this block's.
- **Operand selection:**
  - ALU_A = PCSRC ? EX_PC : fwd_rs1.
  - ALU_B = ALUSRC ? imm : fwd_rs2.
  - EX_STORE_DATA = fwd_rs2, regardless of ALUSRC.
- **Pass-through:** ALU_CTRL and ALU_BRANCHCOND come straight from registered fields.
- **Latency:** ID inputs appear on EX outputs one cycle later; forwarding adds no cycles.
- **Reset mid-stall:** RST wins; STALL deasserts the cycle after, once EX holds a bubble.

Test Plan:
- **Reset:** RST=1 for 2 cycles with garbage on ID_* → all outputs 0, ALU_BRANCHCOND=0000, STALL=0.
- **Basic capture:** ID add x3,x1,x2 with RS1_DATA=5, RS2_DATA=7, CTRL=0000 → next cycle ALU_A=5, ALU_B=7, EX_RD=3, EX_REGWRITE=1.
- **Forward priority:** EX holds rs1=3; EXMEM_RD=3 with EXMEM_RESULT=0xAA; MEMWB_RD=3 with MEMWB_RESULT=0xBB → ALU_A=0xAA. Drop EXMEM_REGWRITE → ALU_A=0xBB. Set RD=0 on both → registered data.
- **Load-use:** EX holds lw x5 (MEMREAD=1, RD=5); ID holds add x6,x5,x1 → STALL=1 for exactly one cycle. Next EX is a bubble (EX_VALID=0). The add enters on the following edge.
- **Flush:** FLUSH=1 while ID holds beq with BRANCHCOND=1000 → next cycle EX_VALID=0 and ALU_BRANCHCOND=0000. FLUSH together with a load-use match → STALL=0.
- **Immediate/PC paths:**
  - addi with IMM=0xFFFFFFFC, ALUSRC=1, rs2 forwarded as 0x11 → ALU_B=0xFFFFFFFC, EX_STORE_DATA=0x11.
  - auipc with PCSRC=1 and PC=0x100 → ALU_A=0x100.
